// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle RV32I controller: FSM state codes,
// opcode constants, datapath control bundle, select encodings and trap causes.
package controller_pkg;

   // FSM state codes, kept as plain constants for legacy tool flows
   typedef logic [2:0] state_t;
   localparam state_t FETCH     = 3'd0;
   localparam state_t DECODE    = 3'd1;
   localparam state_t EXECUTE   = 3'd2;
   localparam state_t MEMORY    = 3'd3;
   localparam state_t WRITEBACK = 3'd4;
   localparam state_t TRAP      = 3'd5;

   // RV32I major opcodes
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   // mcause codes raised by the controller
   localparam logic [3:0] CAUSE_ILLEGAL_INSTRUCTION = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT          = 4'd3;
   localparam logic [3:0] CAUSE_LOAD_MISALIGNED     = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED    = 4'd6;
   localparam logic [3:0] CAUSE_ECALL_M             = 4'd11;

   // Instruction class as seen by the FSM
   typedef enum logic [3:0] {
      CLASS_ILLEGAL = 4'd0,
      CLASS_OP      = 4'd1,
      CLASS_OP_IMM  = 4'd2,
      CLASS_LUI     = 4'd3,
      CLASS_AUIPC   = 4'd4,
      CLASS_JAL     = 4'd5,
      CLASS_JALR    = 4'd6,
      CLASS_BRANCH  = 4'd7,
      CLASS_LOAD    = 4'd8,
      CLASS_STORE   = 4'd9,
      CLASS_CSR     = 4'd10,
      CLASS_MRET    = 4'd11,
      CLASS_ECALL   = 4'd12,
      CLASS_EBREAK  = 4'd13
   } op_class_t;

   // Every encoding reserves 0 as "unused" so an idle bundle is all zeros
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2,
      IMM_B    = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5
   } immediate_type_t;

   typedef enum logic [2:0] {
      ALU_NONE = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2,
      ALU_AND  = 3'd3, ALU_OR  = 3'd4, ALU_XOR = 3'd5
   } alu_type_t;

   typedef enum logic [1:0] {
      SHIFT_NONE = 2'd0, SHIFT_SLL = 2'd1, SHIFT_SRL = 2'd2, SHIFT_SRA = 2'd3
   } shift_type_t;

   typedef enum logic [2:0] {
      CMP_NONE = 3'd0, CMP_EQ  = 3'd1, CMP_NE  = 3'd2, CMP_LT = 3'd3,
      CMP_GE   = 3'd4, CMP_LTU = 3'd5, CMP_GEU = 3'd6
   } compare_type_t;

   typedef enum logic [2:0] {
      LOAD_NONE = 3'd0, LOAD_LB = 3'd1, LOAD_LH = 3'd2,
      LOAD_LW   = 3'd3, LOAD_LBU = 3'd4, LOAD_LHU = 3'd5
   } load_type_t;

   typedef enum logic [1:0] {
      STORE_NONE = 2'd0, STORE_SB = 2'd1, STORE_SH = 2'd2, STORE_SW = 2'd3
   } store_type_t;

   // Datapath control bundle
   typedef struct packed {
      logic            instruction_write_enable;
      logic            use_execute_result_for_read_memory;
      logic            execute_result_write_enable;
      logic            load_memory_data_write_enable;
      logic            register_file_write_enable;
      logic            pc_write_enable;
      logic            write_execute_result_to_pc;
      logic            write_execute_result_to_pc_if_compare_met;
      logic            write_pc_inc_to_register_file;
      logic            write_immediate_to_register_file;
      logic            write_load_memory_to_register_file;
      logic            handle_trap;
      logic            exit_trap;
      logic            execute_alu;
      logic            execute_shift;
      logic            execute_compare;
      logic            execute_csr;
      logic            use_pc_for_alu;
      logic            use_immediate_for_alu;
      immediate_type_t immediate_type;
      alu_type_t       alu_type;
      shift_type_t     shift_type;
      compare_type_t   compare_type;
      load_type_t      load_memory_decoder_type;
      store_type_t     store_memory_encoder_type;
   } control_t;

   // Load data extraction type from funct3
   function automatic load_type_t load_type_f(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return LOAD_LB;
         3'b001:  return LOAD_LH;
         3'b010:  return LOAD_LW;
         3'b100:  return LOAD_LBU;
         3'b101:  return LOAD_LHU;
         default: return LOAD_NONE;
      endcase
   endfunction

   // Store data placement type from funct3
   function automatic store_type_t store_type_f(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return STORE_SB;
         3'b001:  return STORE_SH;
         3'b010:  return STORE_SW;
         default: return STORE_NONE;
      endcase
   endfunction

   // Branch condition from funct3
   function automatic compare_type_t branch_compare_f(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return CMP_EQ;
         3'b001:  return CMP_NE;
         3'b100:  return CMP_LT;
         3'b101:  return CMP_GE;
         3'b110:  return CMP_LTU;
         3'b111:  return CMP_GEU;
         default: return CMP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory handshake between the controller (master) and memory/datapath (slave).
interface multicycle_controller_if;
   logic memory_read_request;
   logic memory_write_request;
   logic memory_command;
   logic memory_ready;
   logic misaligned_exception;

   modport master (
      output memory_read_request,
      output memory_write_request,
      output memory_command,
      input  memory_ready,
      input  misaligned_exception
   );

   modport slave (
      input  memory_read_request,
      input  memory_write_request,
      input  memory_command,
      output memory_ready,
      output misaligned_exception
   );
endinterface

// File: rtl/multicycle_controller_decoder.sv
// Combinational instruction decoder: classifies the latched instruction and
// produces the control bundle that applies during the EXECUTE cycle.
module instruction_decoder
   import controller_pkg::*;
(
   input  logic [31:0] instruction,
   output op_class_t   op_class,
   output control_t    execute_control,
   output logic        illegal
);

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic        alt_s;
   logic [11:0] imm12_s;
   logic        unused_fields_s;

   assign opcode_s = instruction[6:0];
   assign funct3_s = instruction[14:12];
   assign alt_s    = instruction[30];
   assign imm12_s  = instruction[31:20];
   // register indices are the datapath's business, not the controller's
   assign unused_fields_s = ^{instruction[19:15], instruction[11:7]};

   // Classify the opcode; SYSTEM is split by funct3 and the 12-bit immediate
   always_comb begin
      op_class = CLASS_ILLEGAL;
      case (opcode_s)
         OPCODE_OP:     op_class = CLASS_OP;
         OPCODE_OP_IMM: op_class = CLASS_OP_IMM;
         OPCODE_LUI:    op_class = CLASS_LUI;
         OPCODE_AUIPC:  op_class = CLASS_AUIPC;
         OPCODE_JAL:    op_class = CLASS_JAL;
         OPCODE_JALR:   op_class = CLASS_JALR;
         OPCODE_BRANCH: op_class = CLASS_BRANCH;
         OPCODE_LOAD:   op_class = CLASS_LOAD;
         OPCODE_STORE:  op_class = CLASS_STORE;
         OPCODE_SYSTEM: begin
            if (funct3_s == 3'b000) begin
               case (imm12_s)
                  12'h000: op_class = CLASS_ECALL;
                  12'h001: op_class = CLASS_EBREAK;
                  12'h302: op_class = CLASS_MRET;
                  default: op_class = CLASS_ILLEGAL;
               endcase
            end else if (funct3_s == 3'b100) begin
               op_class = CLASS_ILLEGAL;
            end else begin
               op_class = CLASS_CSR;
            end
         end
         default:       op_class = CLASS_ILLEGAL;
      endcase
   end

   assign illegal = (op_class == CLASS_ILLEGAL);

   // Opcode-specific execute-phase selects; everything else stays zero
   always_comb begin
      execute_control = '0;
      case (op_class)
         CLASS_OP, CLASS_OP_IMM: begin
            execute_control.use_immediate_for_alu = (op_class == CLASS_OP_IMM);
            execute_control.immediate_type = (op_class == CLASS_OP_IMM) ? IMM_I : IMM_NONE;
            case (funct3_s)
               3'b000: begin
                  execute_control.execute_alu = 1'b1;
                  // only register-register form has SUB; ADDI's bit 30 is immediate
                  execute_control.alu_type = (op_class == CLASS_OP && alt_s) ? ALU_SUB : ALU_ADD;
               end
               3'b001: begin
                  execute_control.execute_shift = 1'b1;
                  execute_control.shift_type    = SHIFT_SLL;
               end
               3'b010: begin
                  execute_control.execute_compare = 1'b1;
                  execute_control.compare_type    = CMP_LT;
               end
               3'b011: begin
                  execute_control.execute_compare = 1'b1;
                  execute_control.compare_type    = CMP_LTU;
               end
               3'b100: begin
                  execute_control.execute_alu = 1'b1;
                  execute_control.alu_type    = ALU_XOR;
               end
               3'b101: begin
                  execute_control.execute_shift = 1'b1;
                  execute_control.shift_type    = alt_s ? SHIFT_SRA : SHIFT_SRL;
               end
               3'b110: begin
                  execute_control.execute_alu = 1'b1;
                  execute_control.alu_type    = ALU_OR;
               end
               default: begin
                  execute_control.execute_alu = 1'b1;
                  execute_control.alu_type    = ALU_AND;
               end
            endcase
         end
         CLASS_AUIPC: begin
            execute_control.execute_alu           = 1'b1;
            execute_control.alu_type              = ALU_ADD;
            execute_control.use_pc_for_alu        = 1'b1;
            execute_control.use_immediate_for_alu = 1'b1;
            execute_control.immediate_type        = IMM_U;
         end
         CLASS_JAL: begin
            execute_control.execute_alu           = 1'b1;
            execute_control.alu_type              = ALU_ADD;
            execute_control.use_pc_for_alu        = 1'b1;
            execute_control.use_immediate_for_alu = 1'b1;
            execute_control.immediate_type        = IMM_J;
         end
         CLASS_JALR: begin
            execute_control.execute_alu           = 1'b1;
            execute_control.alu_type              = ALU_ADD;
            execute_control.use_immediate_for_alu = 1'b1;
            execute_control.immediate_type        = IMM_I;
         end
         CLASS_BRANCH: begin
            execute_control.execute_alu           = 1'b1;
            execute_control.alu_type              = ALU_ADD;
            execute_control.use_pc_for_alu        = 1'b1;
            execute_control.use_immediate_for_alu = 1'b1;
            execute_control.immediate_type        = IMM_B;
            execute_control.execute_compare       = 1'b1;
            execute_control.compare_type          = branch_compare_f(funct3_s);
         end
         CLASS_LOAD, CLASS_STORE: begin
            execute_control.execute_alu           = 1'b1;
            execute_control.alu_type              = ALU_ADD;
            execute_control.use_immediate_for_alu = 1'b1;
            execute_control.immediate_type        = (op_class == CLASS_STORE) ? IMM_S : IMM_I;
         end
         CLASS_CSR:  execute_control.execute_csr = 1'b1;
         CLASS_MRET: execute_control.exit_trap   = 1'b1;
         default:    execute_control = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP FSM
// driving the datapath control bundle and the memory request handshake.
module multicycle_controller
   import controller_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             instruction,
   multicycle_controller_if.master mem_bus,
   output control_t                control,
   output logic [3:0]              trap_cause,
   output state_t                  state
);

   state_t     state_q, state_d;
   logic [3:0] trap_cause_q, trap_cause_d;
   logic       mem_first_q, mem_first_d;

   op_class_t  op_class_s;
   control_t   exec_ctrl_s;
   logic       illegal_s;
   control_t   ctrl_s;
   logic       read_req_s;
   logic       write_req_s;
   logic       command_s;
   logic       is_load_s;
   logic       is_store_s;
   logic [2:0] funct3_s;
   logic       unused_instr_s;

   instruction_decoder u_decoder (
      .instruction     (instruction),
      .op_class        (op_class_s),
      .execute_control (exec_ctrl_s),
      .illegal         (illegal_s)
   );

   assign is_load_s      = (op_class_s == CLASS_LOAD);
   assign is_store_s     = (op_class_s == CLASS_STORE);
   assign funct3_s       = instruction[14:12];
   assign unused_instr_s = ^{instruction[31:15], instruction[11:0]};

   // Next-state, trap cause capture and per-state control generation
   always_comb begin
      state_d      = state_q;
      trap_cause_d = trap_cause_q;
      mem_first_d  = 1'b0;
      ctrl_s       = '0;
      read_req_s   = 1'b0;
      write_req_s  = 1'b0;
      command_s    = 1'b0;
      case (state_q)
         FETCH: begin
            read_req_s = 1'b1;
            if (mem_bus.memory_ready) begin
               ctrl_s.instruction_write_enable = 1'b1;
               state_d = DECODE;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            // register file reads settle here; no enables
            if (illegal_s) begin
               state_d      = TRAP;
               trap_cause_d = CAUSE_ILLEGAL_INSTRUCTION;
            end else if (op_class_s == CLASS_ECALL) begin
               state_d      = TRAP;
               trap_cause_d = CAUSE_ECALL_M;
            end else if (op_class_s == CLASS_EBREAK) begin
               state_d      = TRAP;
               trap_cause_d = CAUSE_BREAKPOINT;
            end else begin
               state_d = EXECUTE;
            end
         end
         EXECUTE: begin
            ctrl_s = exec_ctrl_s;
            ctrl_s.execute_result_write_enable = 1'b1;
            if (is_load_s || is_store_s) begin
               state_d     = MEMORY;
               mem_first_d = 1'b1;
            end else begin
               state_d = WRITEBACK;
            end
         end
         MEMORY: begin
            command_s = is_store_s;
            ctrl_s.use_execute_result_for_read_memory = 1'b1;
            ctrl_s.load_memory_decoder_type  = is_load_s  ? load_type_f(funct3_s)  : LOAD_NONE;
            ctrl_s.store_memory_encoder_type = is_store_s ? store_type_f(funct3_s) : STORE_NONE;
            // misalignment is only judged on the address of the first cycle
            if (mem_first_q && mem_bus.misaligned_exception) begin
               state_d      = TRAP;
               trap_cause_d = is_store_s ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
            end else begin
               read_req_s  = is_load_s;
               write_req_s = is_store_s;
               if (mem_bus.memory_ready) begin
                  ctrl_s.load_memory_data_write_enable = is_load_s;
                  state_d = WRITEBACK;
               end else begin
                  state_d = MEMORY;
               end
            end
         end
         WRITEBACK: begin
            ctrl_s.pc_write_enable = 1'b1;
            case (op_class_s)
               CLASS_OP, CLASS_OP_IMM, CLASS_AUIPC, CLASS_CSR: begin
                  ctrl_s.register_file_write_enable = 1'b1;
               end
               CLASS_LUI: begin
                  ctrl_s.register_file_write_enable       = 1'b1;
                  ctrl_s.write_immediate_to_register_file = 1'b1;
               end
               CLASS_JAL, CLASS_JALR: begin
                  ctrl_s.register_file_write_enable    = 1'b1;
                  ctrl_s.write_pc_inc_to_register_file = 1'b1;
                  ctrl_s.write_execute_result_to_pc    = 1'b1;
               end
               CLASS_LOAD: begin
                  ctrl_s.register_file_write_enable         = 1'b1;
                  ctrl_s.write_load_memory_to_register_file = 1'b1;
               end
               CLASS_BRANCH: ctrl_s.write_execute_result_to_pc_if_compare_met = 1'b1;
               CLASS_MRET:   ctrl_s.write_execute_result_to_pc = 1'b1;
               default:      ctrl_s.register_file_write_enable = 1'b0;
            endcase
            state_d = FETCH;
         end
         TRAP: begin
            ctrl_s.handle_trap     = 1'b1;
            ctrl_s.pc_write_enable = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // State, trap cause and first-memory-cycle flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FETCH;
         trap_cause_q <= 4'd0;
         mem_first_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         trap_cause_q <= trap_cause_d;
         mem_first_q  <= mem_first_d;
      end
   end

   // Outputs are forced low the instant reset asserts, even mid-request
   always_comb begin
      if (reset) begin
         control                      = ctrl_s;
         mem_bus.memory_read_request  = read_req_s;
         mem_bus.memory_write_request = write_req_s;
         mem_bus.memory_command       = command_s;
         trap_cause                   = (state_q == TRAP) ? trap_cause_q : 4'd0;
      end else begin
         control                      = '0;
         mem_bus.memory_read_request  = 1'b0;
         mem_bus.memory_write_request = 1'b0;
         mem_bus.memory_command       = 1'b0;
         trap_cause                   = 4'd0;
      end
   end

   assign state = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port instruction, input, 32, latched instruction from the datapath.
REQ-004 SHALL have port memory_ready, input, 1, memory request completes in a cycle where this is high.
REQ-005 SHALL have port misaligned_exception, input, 1, datapath load/store misalignment flag.
REQ-006 SHALL have port memory_read_request, output, 1, read request, held until memory_ready.
REQ-007 SHALL have port memory_write_request, output, 1, write request, held until memory_ready.
REQ-008 SHALL have port memory_command, output, 1; 0 = load, 1 = store; datapath misalignment select.
REQ-009 SHALL have port control, output, control_t, packed datapath control bundle.
REQ-010 SHALL have port trap_cause, output, 4, mcause code, valid while state is TRAP.
REQ-011 SHALL have port state, output, state_t, current FSM state, for debug.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
REQ-013 FETCH SHALL be entered from reset and after every retire or trap.
- In FETCH: memory_read_request=1 and use_execute_result_for_read_memory=0.
- On memory_ready: instruction_write_enable=1; next state DECODE.
- Without memory_ready: remain in FETCH; no enables.
REQ-014 DECODE SHALL last exactly 1 cycle with no enables asserted, for register-file read settle.
- Unknown opcode, or unknown SYSTEM funct3/imm: go to TRAP with cause 2.
- Otherwise: go to EXECUTE.
REQ-015 EXECUTE SHALL last 1 cycle.
- Drives the opcode-specific execute_*, use_*, immediate_type, alu_type, shift_type and compare_type fields.
- Asserts execute_result_write_enable.
- Next state: MEMORY for LOAD/STORE; WRITEBACK for all other opcodes.
REQ-016 Opcode mapping in EXECUTE SHALL be:
- OP/OP-IMM: alu, shift or compare (SLT/SLTU) selected by funct3/funct7.
- AUIPC: alu add with use_pc_for_alu.
- JAL: pc+J-immediate.
- JALR: rs1+I-immediate.
- BRANCH: alu pc+B-immediate with execute_compare per funct3.
- LOAD/STORE: alu rs1+immediate.
- CSR: execute_csr.
- MRET: exit_trap.
- LUI: EXECUTE SHALL still occur, with no result used.
REQ-017 MEMORY SHALL behave as follows.
- Drive memory_command and use_execute_result_for_read_memory=1, plus load_memory_decoder_type/store_memory_encoder_type from funct3.
- If misaligned_exception=1 in its first cycle: no memory request; next state TRAP with cause 4 (load) or 6 (store).
- Otherwise: assert the read or write request until memory_ready.
- On memory_ready for a load: load_memory_data_write_enable=1.
- Next state: WRITEBACK.
REQ-018 WRITEBACK SHALL last 1 cycle and assert pc_write_enable.
- Asserts register_file_write_enable for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD and CSR.
- Asserts write_execute_result_to_pc for JAL, JALR and MRET.
- Asserts write_execute_result_to_pc_if_compare_met for BRANCH.
- Source select: write_pc_inc_to_register_file for JAL/JALR; write_immediate_to_register_file for LUI; write_load_memory_to_register_file for LOAD.
- Next state: FETCH.
REQ-019 TRAP SHALL last 1 cycle, asserting handle_trap and pc_write_enable with no register write; next state FETCH.
REQ-020 ECALL SHALL enter TRAP with cause 11; EBREAK SHALL enter TRAP with cause 3.
REQ-021 Every control field not named for the current state SHALL be 0.
REQ-022 Latency with memory_ready tied high SHALL be:
- 4 cycles for non-memory instructions.
- 5 cycles for load/store.
- Each memory-ready-low cycle adds 1 cycle.
REQ-023 memory_read_request and memory_write_request SHALL never be high simultaneously.

Reset
REQ-024 While reset=0, the FSM SHALL be in FETCH and the controller SHALL assert no outputs.
- All outputs are 0, including control, requests and trap_cause.
- Reset asserted mid-request SHALL drop the request immediately, asynchronously.
REQ-025 After reset release, the first FETCH request SHALL appear in the first cycle.

Structure
REQ-026 Package controller_pkg SHALL hold:
- state_t.
- control_t, with all datapath select/enable fields and type codes.
- The opcode constants.
- The alu_type, shift_type, compare_type, immediate_type and load/store type encodings.
- The trap cause codes.
REQ-027 SHALL contain one sub-module, instruction_decoder: combinational, instruction -> opcode class, EXECUTE-phase control_t and illegal flag.

Verification
REQ-028 Cover the following directed scenarios:
- ADDI x1,x0,5 (0x00500093), memory_ready=1: register_file_write_enable and pc_write_enable high only in cycle 4 after the fetch request.
- FETCH with memory_ready low for 3 cycles: read request held for 4 cycles; instruction_write_enable only in the 4th.
- BEQ x0,x0,+8 (0x00000463): write_execute_result_to_pc_if_compare_met=1 in WRITEBACK; compare_type=EQ in EXECUTE.
- LW with misaligned_exception=1: no read request in MEMORY; TRAP next cycle with trap_cause=4 and handle_trap=1; no register write.
- Instruction 0x00000000: TRAP with cause 2 directly after DECODE.
- Reset low during a MEMORY wait: outputs immediately 0; state FETCH; request asserted 1 cycle after release.
